// File: rtl/ascon_perm_ctrl_if.sv
// Request/completion handshakes and round outputs between the Ascon mode FSM,
// the permutation sequencer and the round datapath.
interface ascon_perm_ctrl_if #(
  parameter int RndWidth   = 4,
  parameter int ConstWidth = 8
);
  logic                  start_valid_i;
  logic                  start_p12_i;
  logic                  start_ready_o;
  logic                  abort_i;
  logic                  state_load_o;
  logic                  round_en_o;
  logic [RndWidth-1:0]   round_o;
  logic [ConstWidth-1:0] const_o;
  logic                  last_round_o;
  logic                  busy_o;
  logic                  done_valid_o;
  logic                  done_ready_i;

  modport master (
    output start_valid_i, start_p12_i, abort_i, done_ready_i,
    input  start_ready_o, state_load_o, round_en_o, round_o, const_o,
           last_round_o, busy_o, done_valid_o
  );

  modport slave (
    input  start_valid_i, start_p12_i, abort_i, done_ready_i,
    output start_ready_o, state_load_o, round_en_o, round_o, const_o,
           last_round_o, busy_o, done_valid_o
  );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the Ascon permutation: accepts p12/p6 requests, steps the
// round index up to 11, emits round constants and datapath enables.
module ascon_perm_ctrl #(
  parameter int RndWidth   = 4,
  parameter int ConstWidth = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ascon_perm_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [RndWidth-1:0] LastRnd = RndWidth'(11);
  localparam logic [RndWidth-1:0] P6First = RndWidth'(6);

  state_t              state_q, state_d;
  logic [RndWidth-1:0] rnd_q, rnd_d;

  // Constant for round r is ((15-r)<<4)|r, i.e. the low nibble and its complement.
  function automatic logic [ConstWidth-1:0] round_const(input logic [RndWidth-1:0] r);
    logic [7:0] c;
    c = {~r[3:0], r[3:0]};
    return ConstWidth'(c);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    rnd_d            = rnd_q;
    bus.start_ready_o = 1'b0;
    bus.state_load_o  = 1'b0;
    bus.round_en_o    = 1'b0;
    bus.const_o       = '0;
    bus.last_round_o  = 1'b0;
    bus.busy_o        = 1'b0;
    bus.done_valid_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.start_ready_o = 1'b1;
        if (bus.start_valid_i && !bus.abort_i) begin
          bus.state_load_o = 1'b1;
          rnd_d            = bus.start_p12_i ? '0 : P6First;
          state_d          = RUN;
        end
      end
      RUN: begin
        bus.round_en_o   = 1'b1;
        bus.busy_o       = 1'b1;
        bus.const_o      = round_const(rnd_q);
        bus.last_round_o = (rnd_q == LastRnd);
        if (rnd_q == LastRnd) state_d = DONE;
        else                  rnd_d   = rnd_q + RndWidth'(1);
      end
      DONE: begin
        bus.busy_o       = 1'b1;
        bus.done_valid_o = 1'b1;
        if (bus.done_ready_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition but leaves this cycle's outputs alone.
    if (bus.abort_i) begin
      state_d = IDLE;
      rnd_d   = '0;
    end
  end

  assign bus.round_o = rnd_q;

endmodule
